// File: rtl/simd_pkg.sv
// Shared constants and types for the SIMD result drain path.
package simd_pkg;

  localparam int DIM_ROW1  = 2;
  localparam int DIM_COL2  = 2;
  localparam int ACC_WIDTH = 16;
  localparam int OUT_WIDTH = 8;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} drain_state_t;

  // Index width; a single-element matrix still gets a 1-bit index
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(DIM_ROW1 * DIM_COL2);

endpackage

// File: rtl/acc_narrow.sv
// Narrows one accumulator value to the streamed width (saturate or truncate).
module acc_narrow #(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter bit SAT_EN    = 1'b1
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0] res
);

  generate
    if (SAT_EN && (OUT_WIDTH < ACC_WIDTH)) begin : g_sat
      // Any set bit above the output range means the value does not fit
      always_comb begin
        res = acc[OUT_WIDTH-1:0];
        if (|acc[ACC_WIDTH-1:OUT_WIDTH]) res = '1;
      end
    end else begin : g_trunc
      assign res = acc[OUT_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/simd_result_drain.sv
// Snapshots the SIMD cell result vector and streams it out element by element.
module simd_result_drain
  import simd_pkg::*;
#(
  parameter int NUM_ELEM  = 4,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter bit SAT_EN    = 1'b1,
  localparam int IW       = idx_w(NUM_ELEM)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               capture,
  input  logic [NUM_ELEM-1:0][ACC_WIDTH-1:0] acc_in,
  input  logic                               out_ready,
  input  logic                               clear_overrun,
  output logic                               out_valid,
  output logic [OUT_WIDTH-1:0]               out_data,
  output logic [IW-1:0]                      out_idx,
  output logic                               out_last,
  output logic                               busy,
  output logic                               overrun
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEM - 1);

  drain_state_t                       state_q, state_d;
  logic [NUM_ELEM-1:0][ACC_WIDTH-1:0] buf_q, buf_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic                               ovr_q, ovr_d;
  logic                               xfer, at_last, drop;
  logic [ACC_WIDTH-1:0]               elem;
  logic [OUT_WIDTH-1:0]               narrowed;

  // State, buffer, index and sticky overrun registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  assign xfer    = (state_q == STREAM) && out_ready;
  assign at_last = (idx_q == LAST_IDX);

  // Next state: a capture on the final transfer relatches with no bubble;
  // a capture at any other point of a stream is dropped and flagged
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = STREAM;
          buf_d   = acc_in;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (xfer && at_last) begin
          idx_d = '0;
          if (capture) buf_d = acc_in;
          else         state_d = IDLE;
        end else begin
          if (xfer) idx_d = idx_q + IW'(1);
          drop = capture;
        end
      end
      default: state_d = IDLE;
    endcase
    // Set beats clear when both happen together
    ovr_d = ovr_q;
    if (clear_overrun) ovr_d = 1'b0;
    if (drop)          ovr_d = 1'b1;
  end

  generate
    if (NUM_ELEM > 1) begin : g_mux
      assign elem = buf_q[idx_q];
    end else begin : g_single
      assign elem = buf_q[0];
    end
  endgenerate

  acc_narrow #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SAT_EN   (SAT_EN)
  ) u_narrow (
    .acc(elem),
    .res(narrowed)
  );

  assign out_valid = (state_q == STREAM);
  assign busy      = out_valid;
  assign out_data  = out_valid ? narrowed : '0;
  assign out_idx   = out_valid ? idx_q : '0;
  assign out_last  = out_valid && at_last;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_simd_result_drain.sv
// Directed bench for simd_result_drain: drain, backpressure, narrowing, overrun, back-to-back, reset.
module tb_simd_result_drain;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             capture;
  logic [3:0][15:0] acc_in;
  logic             out_ready;
  logic             clear_overrun;
  logic             out_valid, out_last, busy, overrun;
  logic [7:0]       out_data;
  logic [1:0]       out_idx;
  // truncating instance shares inputs
  logic             t_valid, t_last, t_busy, t_overrun;
  logic [7:0]       t_data;
  logic [1:0]       t_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simd_result_drain #(.NUM_ELEM(4), .ACC_WIDTH(16), .OUT_WIDTH(8), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .capture(capture), .acc_in(acc_in),
    .out_ready(out_ready), .clear_overrun(clear_overrun),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  simd_result_drain #(.NUM_ELEM(4), .ACC_WIDTH(16), .OUT_WIDTH(8), .SAT_EN(1'b0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .capture(capture), .acc_in(acc_in),
    .out_ready(out_ready), .clear_overrun(clear_overrun),
    .out_valid(t_valid), .out_data(t_data), .out_idx(t_idx),
    .out_last(t_last), .busy(t_busy), .overrun(t_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " busy"},  {31'd0, busy},      32'd0);
    chk({tag, " data"},  {24'd0, out_data},  32'd0);
  endtask

  logic [7:0] expd [4];
  logic [7:0] exps [4];
  logic [7:0] expt [4];
  logic       bp   [7];
  int         cnt;

  initial begin
    rst_n = 1'b0; capture = 1'b0; acc_in = '0; out_ready = 1'b0; clear_overrun = 1'b0;
    expd[0] = 8'd10; expd[1] = 8'd20; expd[2] = 8'd30; expd[3] = 8'd40;
    exps[0] = 8'h07; exps[1] = 8'hFF; exps[2] = 8'hFF; exps[3] = 8'hFF;
    expt[0] = 8'h07; expt[1] = 8'h34; expt[2] = 8'hFF; expt[3] = 8'h00;
    bp[0] = 1; bp[1] = 0; bp[2] = 0; bp[3] = 1; bp[4] = 0; bp[5] = 1; bp[6] = 1;
    #22;
    chk_idle("reset");
    chk("reset idx",     {30'd0, out_idx},  32'd0);
    chk("reset last",    {31'd0, out_last}, 32'd0);
    chk("reset overrun", {31'd0, overrun},  32'd0);
    #3 rst_n = 1'b1;
    tick();

    // basic drain, ready held high
    acc_in = {16'd40, 16'd30, 16'd20, 16'd10};
    out_ready = 1'b1; capture = 1'b1;
    chk("basic pre valid", {31'd0, out_valid}, 32'd0);
    tick(); capture = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic valid %0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("basic data %0d", i),  {24'd0, out_data},  {24'd0, expd[i]});
      chk($sformatf("basic idx %0d", i),   {30'd0, out_idx},   i);
      chk($sformatf("basic last %0d", i),  {31'd0, out_last},  (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk_idle("basic after");

    // backpressure: ready pattern 1,0,0,1,0,1,1 -> exactly four transfers
    capture = 1'b1; tick(); capture = 1'b0;
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      out_ready = bp[k];
      #1;
      chk($sformatf("bp valid %0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp data %0d", k),  {24'd0, out_data},  {24'd0, expd[cnt]});
      chk($sformatf("bp idx %0d", k),   {30'd0, out_idx},   cnt);
      if (bp[k]) cnt++;
      tick();
    end
    chk("bp transfers", cnt, 32'd4);
    chk_idle("bp after");

    // narrowing: saturating and truncating instances side by side
    out_ready = 1'b1;
    acc_in = {16'h0100, 16'h00FF, 16'h1234, 16'h0007};
    capture = 1'b1; tick(); capture = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sat data %0d", i),   {24'd0, out_data}, {24'd0, exps[i]});
      chk($sformatf("trunc data %0d", i), {24'd0, t_data},   {24'd0, expt[i]});
      tick();
    end
    chk_idle("sat after");

    // overrun: capture at idx 1 is dropped, stream keeps original data
    acc_in = {16'd40, 16'd30, 16'd20, 16'd10};
    capture = 1'b1; tick(); capture = 1'b0;
    chk("ovr idx0 data", {24'd0, out_data}, 32'd10);
    tick();
    chk("ovr idx1 data", {24'd0, out_data}, 32'd20);
    acc_in = {16'd99, 16'd98, 16'd97, 16'd96};
    capture = 1'b1; tick(); capture = 1'b0;
    chk("ovr set",       {31'd0, overrun},  32'd1);
    chk("ovr idx2 data", {24'd0, out_data}, 32'd30);
    tick();
    chk("ovr idx3 data", {24'd0, out_data}, 32'd40);
    chk("ovr sticky",    {31'd0, overrun},  32'd1);
    tick();
    chk_idle("ovr end");
    chk("ovr sticky idle", {31'd0, overrun}, 32'd1);
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
    chk("ovr cleared", {31'd0, overrun}, 32'd0);

    // back-to-back: capture B on the last transfer of A
    acc_in = {16'd40, 16'd30, 16'd20, 16'd10};
    capture = 1'b1; tick(); capture = 1'b0;
    tick(); tick(); tick();
    chk("b2b A last", {31'd0, out_last}, 32'd1);
    acc_in = {16'd4, 16'd3, 16'd2, 16'd1};
    capture = 1'b1; tick(); capture = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b valid %0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("b2b data %0d", i),  {24'd0, out_data},  i + 1);
      chk($sformatf("b2b idx %0d", i),   {30'd0, out_idx},   i);
      chk($sformatf("b2b ovr %0d", i),   {31'd0, overrun},   32'd0);
      tick();
    end
    chk_idle("b2b after");

    // reset mid-stream with overrun set
    acc_in = {16'd40, 16'd30, 16'd20, 16'd10};
    capture = 1'b1; tick(); capture = 1'b0;
    tick();
    capture = 1'b1; tick(); capture = 1'b0;
    chk("rst pre idx",     {30'd0, out_idx}, 32'd2);
    chk("rst pre overrun", {31'd0, overrun}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rst async");
    chk("rst async overrun", {31'd0, overrun}, 32'd0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle($sformatf("rst post %0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simd_result_drain.md
Name: simd_result_drain

Overview:
Drains the result matrix from a TLUT SIMD cell. On a capture pulse (driven from the cell's rollover), it snapshots the full parallel `accumulated_mult` vector into a local buffer. It then streams the elements out one per transfer over a valid/ready interface, in row-major order, narrowed to OUT_WIDTH. It sits between the SIMD cell output and the downstream writeback/result FIFO.

Parameters:
NUM_ELEM, 4, number of result elements (DIM_ROW1*DIM_COL2)
ACC_WIDTH, 16, width of each accumulated element (matches `ACC_WIDTH)
OUT_WIDTH, 8, width of each streamed element; must be <= ACC_WIDTH
SAT_EN, 1, 1 = unsigned saturation on narrowing; 0 = truncation (keep low OUT_WIDTH bits)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous reset, active low
capture  input  1  one-cycle pulse: snapshot acc_in
acc_in  input  NUM_ELEM x ACC_WIDTH  packed result vector from the SIMD cell, element 0 in the LSBs
out_ready  input  1  downstream accepts data
clear_overrun  input  1  clears the sticky overrun flag
out_valid  output  1  out_data is valid
out_data  output  OUT_WIDTH  current element, narrowed
out_idx  output  clog2(NUM_ELEM)  index of current element
out_last  output  1  current element is index NUM_ELEM-1
busy  output  1  buffer holds untransferred data
overrun  output  1  sticky: a capture was dropped

Behaviour:
- Reset: all of the following go to 0 and the buffer contents are discarded; state goes to IDLE:
  - out_valid, out_data, out_idx, out_last, busy, overrun.
  - This also applies when reset is asserted mid-stream.
- States: IDLE, STREAM.
- IDLE:
  - capture=1 at edge k latches acc_in into the buffer, sets out_idx=0 and moves to STREAM.
  - out_valid=1 is visible after edge k, so capture-to-first-valid latency is 1 cycle.
- STREAM:
  - out_valid=1 and busy=1.
  - A transfer occurs on any edge where out_valid && out_ready.
  - On a non-last transfer, out_idx increments.
  - While out_valid && !out_ready, out_data, out_idx and out_last are held stable.
- Last transfer (out_idx == NUM_ELEM-1):
  - Without capture in the same cycle: return to IDLE; out_valid=0 and busy=0 next cycle.
  - With capture in the same cycle: relatch acc_in, reset out_idx to 0 and stay in STREAM. This gives back-to-back matrices with no bubble; overrun is not set.
- Capture in STREAM at any other time:
  - The capture is ignored; the buffer is not modified.
  - overrun is set to 1 next cycle and stays sticky.
- Overrun clearing:
  - clear_overrun=1 clears overrun next cycle.
  - If a dropped capture and clear_overrun occur in the same cycle, set wins.
- Narrowing (combinational on the buffer element, values treated as unsigned):
  - SAT_EN=1: out_data = (elem > 2^OUT_WIDTH-1) ? all-ones : elem[OUT_WIDTH-1:0].
  - SAT_EN=0: out_data = elem[OUT_WIDTH-1:0].
  - out_data is 0 whenever out_valid=0.
- out_last = out_valid && (out_idx == NUM_ELEM-1).
- out_ready is ignored while out_valid=0.
- NUM_ELEM=1: every transfer is the last transfer.

Decomposition:
- Shared package simd_pkg:
  - Dimension and width constants: DIM_ROW1, DIM_COL2, ACC_WIDTH, OUT_WIDTH.
  - drain_state_t enum {IDLE, STREAM}.
  - Element index width constant IDX_W = clog2(NUM_ELEM).
- Sub-module acc_narrow: combinational saturate/truncate of one ACC_WIDTH value to OUT_WIDTH, parameterised by SAT_EN. It is instantiated once on the mux output.

Test Plan:
- Basic drain:
  - Stimulus: reset; capture with acc_in={40,30,20,10} (elements 3..0); out_ready held at 1.
  - Required: out_valid rises 1 cycle after capture; out_data streams 10,20,30,40 over 4 consecutive cycles; out_last only on 40; busy falls the cycle after.
- Backpressure:
  - Stimulus: same data; out_ready toggles 1,0,0,1,0,1,1.
  - Required: data/idx are stable during the 0 cycles; exactly 4 transfers occur, in order; no duplicates or drops.
- Saturation:
  - Stimulus: SAT_EN=1, acc_in={0x0100,0x00FF,0x1234,0x0007}.
  - Required: outputs 0x07,0xFF,0xFF,0xFF.
  - Stimulus: SAT_EN=0, same data.
  - Required: outputs 0x07,0x34,0xFF,0x00.
- Overrun:
  - Stimulus: capture at idx 1 of an active stream.
  - Required: stream continues with the original data; overrun=1 next cycle and stays 1; clear_overrun pulse brings it to 0 one cycle later.
- Back-to-back:
  - Stimulus: capture coincides with the last transfer of matrix A; new acc_in is matrix B={4,3,2,1}.
  - Required: the next cycle shows idx 0 of B (data 1) with out_valid continuous; overrun stays 0.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 asynchronously at idx 2.
  - Required: out_valid, busy and overrun drop immediately; after release, no stale elements are emitted until a new capture.
